// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int COMMON_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH        = 2'd0,
    WAIT         = 2'd1,
    WAIT_RESOLVE = 2'd2
  } fetch_state_t;

  localparam logic [COMMON_WIDTH-1:0] INST_BYTES     = 32'd4;
  localparam logic [COMMON_WIDTH-1:0] FETCH_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_if.sv
// Memory-request and decoder-facing signals of the fetch stage, bundled as one interface.
interface inst_fetch_if;
  import fetch_pkg::*;

  logic                    mem_req;
  logic [COMMON_WIDTH-1:0] mem_addr;
  logic                    mem_ready;
  logic                    mem_rvalid;
  logic [COMMON_WIDTH-1:0] mem_rdata;

  logic [COMMON_WIDTH-1:0] inst;
  logic [COMMON_WIDTH-1:0] pc_addr;
  logic                    inst_valid;
  logic                    dec_ready;
  logic                    stall_in;
  logic                    resolve_valid;
  logic [COMMON_WIDTH-1:0] resolve_addr;

  modport master (
    output mem_req, mem_addr, inst, pc_addr, inst_valid,
    input  mem_ready, mem_rvalid, mem_rdata, dec_ready, stall_in,
           resolve_valid, resolve_addr
  );

  modport slave (
    input  mem_req, mem_addr, inst, pc_addr, inst_valid,
    output mem_ready, mem_rvalid, mem_rdata, dec_ready, stall_in,
           resolve_valid, resolve_addr
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues one memory request at a time and
// presents returned words to the decoder, halting on jumps until resolved.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [COMMON_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  fetch_state_t            state_r, state_nxt_s;
  logic [COMMON_WIDTH-1:0] pc_r, pc_nxt_s;
  logic                    kill_r, kill_nxt_s;
  logic [COMMON_WIDTH-1:0] inst_r, inst_nxt_s;
  logic [COMMON_WIDTH-1:0] pc_addr_r, pc_addr_nxt_s;
  logic                    inst_valid_r, inst_valid_nxt_s;

  logic consume_s;
  logic slot_free_s;
  logic mem_req_s;

  assign consume_s   = inst_valid_r & bus.dec_ready;
  assign slot_free_s = ~inst_valid_r | (consume_s & ~bus.stall_in);
  assign mem_req_s   = ~rst & (state_r == FETCH) & slot_free_s & ~bus.resolve_valid;

  assign bus.mem_req    = mem_req_s;
  assign bus.mem_addr   = pc_r;
  assign bus.inst       = inst_r;
  assign bus.pc_addr    = pc_addr_r;
  assign bus.inst_valid = inst_valid_r;

  // Next-state logic: redirect beats everything, then response load, then jump halt.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    kill_nxt_s       = kill_r;
    inst_nxt_s       = inst_r;
    pc_addr_nxt_s    = pc_addr_r;
    inst_valid_nxt_s = inst_valid_r;

    if (bus.resolve_valid) begin
      pc_nxt_s         = bus.resolve_addr;
      inst_valid_nxt_s = 1'b0;
      inst_nxt_s       = FETCH_NOP_INST;
      // A request still in flight must have its response swallowed later.
      if ((state_r == WAIT) && !bus.mem_rvalid) begin
        state_nxt_s = WAIT;
        kill_nxt_s  = 1'b1;
      end else begin
        state_nxt_s = FETCH;
        kill_nxt_s  = 1'b0;
      end
    end else begin
      if (consume_s) begin
        inst_valid_nxt_s = 1'b0;
        inst_nxt_s       = FETCH_NOP_INST;
      end else begin
        inst_valid_nxt_s = inst_valid_r;
      end

      case (state_r)
        FETCH: begin
          if (mem_req_s && bus.mem_ready) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = FETCH;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            if (kill_r) begin
              kill_nxt_s = 1'b0;
            end else begin
              inst_nxt_s       = bus.mem_rdata;
              pc_addr_nxt_s    = pc_r;
              inst_valid_nxt_s = 1'b1;
              pc_nxt_s         = pc_r + INST_BYTES;
            end
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = WAIT;
          end
        end
        WAIT_RESOLVE: begin
          state_nxt_s = WAIT_RESOLVE;
        end
        default: begin
          state_nxt_s = FETCH;
        end
      endcase

      if (consume_s && bus.stall_in) begin
        state_nxt_s = WAIT_RESOLVE;
      end else begin
        state_nxt_s = state_nxt_s;
      end
    end
  end

  // State, PC, kill flag and decoder-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      kill_r       <= 1'b0;
      inst_r       <= FETCH_NOP_INST;
      pc_addr_r    <= 32'h0000_0000;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      kill_r       <= kill_nxt_s;
      inst_r       <= inst_nxt_s;
      pc_addr_r    <= pc_addr_nxt_s;
      inst_valid_r <= inst_valid_nxt_s;
    end
  end

endmodule
